// File: rtl/noc_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : noc_mem_responder_if
// Description : NoC flit definitions shared by the memory responder and its
//               requesters, plus the request/response handshake interface.
//               Ports (slave view = responder):
//                 noc0_mem_val/noc0_mem_data  in   request flit + valid
//                 mem_noc0_rdy                out  request flit accepted
//                 mem_noc0_val/mem_noc0_data  out  response flit + valid
//                 noc0_mem_rdy                in   response flit accepted
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef NOC_MEM_RESPONDER_DEFS_SVH
`define NOC_MEM_RESPONDER_DEFS_SVH

`define NOC_DATA_WIDTH       256
`define NOC_DATA_BYTES       32
`define NOC_DATA_BYTES_W     5
`define NOC_CHIP_ID_WIDTH    14
`define NOC_X_WIDTH          8
`define NOC_Y_WIDTH          8
`define MSG_LENGTH_WIDTH     8
`define MSG_TYPE_WIDTH       8
`define NOC_ADDR_WIDTH       48
`define NOC_DATA_SIZE_WIDTH  16

`define MSG_TYPE_LOAD_MEM       8'd19
`define MSG_TYPE_STORE_MEM      8'd20
`define MSG_TYPE_LOAD_MEM_ACK   8'd24
`define MSG_TYPE_STORE_MEM_ACK  8'd25

// Bit positions of the header fields; must agree with noc_hdr_flit below.
`define NOC_HDR_DATA_SIZE_LSB  0
`define NOC_HDR_ADDR_LSB       16
`define NOC_HDR_SRC_Y_LSB      64
`define NOC_HDR_SRC_X_LSB      72
`define NOC_HDR_SRC_CHIP_LSB   80
`define NOC_HDR_MSG_TYPE_LSB   94
`define NOC_HDR_MSG_LEN_LSB    102
`define NOC_HDR_DST_Y_LSB      110
`define NOC_HDR_DST_X_LSB      118
`define NOC_HDR_DST_CHIP_LSB   126

typedef struct packed {
  logic [`NOC_DATA_WIDTH-141:0]      rsvd;
  logic [`NOC_CHIP_ID_WIDTH-1:0]     dst_chip_id;
  logic [`NOC_X_WIDTH-1:0]           dst_x_coord;
  logic [`NOC_Y_WIDTH-1:0]           dst_y_coord;
  logic [`MSG_LENGTH_WIDTH-1:0]      msg_len;
  logic [`MSG_TYPE_WIDTH-1:0]        msg_type;
  logic [`NOC_CHIP_ID_WIDTH-1:0]     src_chip_id;
  logic [`NOC_X_WIDTH-1:0]           src_x_coord;
  logic [`NOC_Y_WIDTH-1:0]           src_y_coord;
  logic [`NOC_ADDR_WIDTH-1:0]        addr;
  logic [`NOC_DATA_SIZE_WIDTH-1:0]   data_size;
} noc_hdr_flit;

`endif

interface noc_mem_responder_if;
  logic                       noc0_mem_val;
  logic [`NOC_DATA_WIDTH-1:0] noc0_mem_data;
  logic                       mem_noc0_rdy;
  logic                       mem_noc0_val;
  logic [`NOC_DATA_WIDTH-1:0] mem_noc0_data;
  logic                       noc0_mem_rdy;

  modport slave (
    input  noc0_mem_val, noc0_mem_data, noc0_mem_rdy,
    output mem_noc0_rdy, mem_noc0_val, mem_noc0_data
  );

  modport master (
    output noc0_mem_val, noc0_mem_data, noc0_mem_rdy,
    input  mem_noc0_rdy, mem_noc0_val, mem_noc0_data
  );
endinterface

`default_nettype wire

// File: rtl/noc_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : noc_mem_responder
// Description : NoC memory endpoint. Accepts STORE_MEM / LOAD_MEM requests on
//               noc0, backs them with a flop-array memory and answers with
//               STORE_MEM_ACK / LOAD_MEM_ACK (plus payload for loads).
//               Ports:
//                 clk, rst     clock, synchronous active-high reset
//                 noc          request/response handshake (slave modport)
//                 err_bad_msg  one-cycle pulse on a dropped unsupported header
// Revision    : 1.0 - initial release
// ============================================================================
module noc_mem_responder #(
  parameter int MEM_DEPTH   = 256,
  parameter int SRC_CHIP_ID = 0,
  parameter int SRC_X       = 1,
  parameter int SRC_Y       = 0
) (
  input  wire                clk,
  input  wire                rst,
  noc_mem_responder_if.slave noc,
  output logic               err_bad_msg
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int BW    = `NOC_DATA_BYTES_W;
  localparam int DW    = `NOC_DATA_WIDTH;
  localparam int LW    = `MSG_LENGTH_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE          = 3'd0,
    S_STORE_PAYLOAD = 3'd1,
    S_STORE_ACK     = 3'd2,
    S_LOAD_HDR      = 3'd3,
    S_LOAD_PAYLOAD  = 3'd4
  } state_e;

  state_e                           state_q, state_d;
  logic [IDX_W-1:0]                 idx_q, idx_d;
  logic [LW-1:0]                    cnt_q, cnt_d;
  logic [`MSG_TYPE_WIDTH-1:0]       msg_type_q, msg_type_d;
  logic [`NOC_ADDR_WIDTH-1:0]       addr_q, addr_d;
  logic [`NOC_DATA_SIZE_WIDTH-1:0]  data_size_q, data_size_d;
  logic [LW-1:0]                    msg_len_q, msg_len_d;
  logic [`NOC_CHIP_ID_WIDTH-1:0]    req_chip_q, req_chip_d;
  logic [`NOC_X_WIDTH-1:0]          req_x_q, req_x_d;
  logic [`NOC_Y_WIDTH-1:0]          req_y_q, req_y_d;

  logic [DW-1:0]                    mem_q [MEM_DEPTH];
  logic                             mem_we;

  // Header fields of the incoming flit, only meaningful in S_IDLE.
  logic [`MSG_TYPE_WIDTH-1:0]       req_type;
  logic [`NOC_ADDR_WIDTH-1:0]       req_addr;
  logic [`NOC_DATA_SIZE_WIDTH-1:0]  req_size;
  logic [LW-1:0]                    req_len;
  logic [`NOC_CHIP_ID_WIDTH-1:0]    req_chip;
  logic [`NOC_X_WIDTH-1:0]          req_x;
  logic [`NOC_Y_WIDTH-1:0]          req_y;

  assign req_type = noc.noc0_mem_data[`NOC_HDR_MSG_TYPE_LSB  +: `MSG_TYPE_WIDTH];
  assign req_addr = noc.noc0_mem_data[`NOC_HDR_ADDR_LSB      +: `NOC_ADDR_WIDTH];
  assign req_size = noc.noc0_mem_data[`NOC_HDR_DATA_SIZE_LSB +: `NOC_DATA_SIZE_WIDTH];
  assign req_len  = noc.noc0_mem_data[`NOC_HDR_MSG_LEN_LSB   +: LW];
  assign req_chip = noc.noc0_mem_data[`NOC_HDR_SRC_CHIP_LSB  +: `NOC_CHIP_ID_WIDTH];
  assign req_x    = noc.noc0_mem_data[`NOC_HDR_SRC_X_LSB     +: `NOC_X_WIDTH];
  assign req_y    = noc.noc0_mem_data[`NOC_HDR_SRC_Y_LSB     +: `NOC_Y_WIDTH];

  logic [LW-1:0]    resp_len;
  logic [LW-1:0]    cnt_inc;
  logic [IDX_W-1:0] idx_inc;
  logic             is_load_q;
  noc_hdr_flit      resp_hdr;

  always_comb begin
    // Round data_size up to whole flits; truncation to the length field is intended.
    resp_len  = LW'((data_size_q >> BW) +
                    `NOC_DATA_SIZE_WIDTH'(|data_size_q[BW-1:0]));
    cnt_inc   = cnt_q + LW'(1);
    idx_inc   = idx_q + IDX_W'(1);   // power-of-two depth wraps naturally
    is_load_q = (msg_type_q == `MSG_TYPE_LOAD_MEM);

    resp_hdr             = '0;
    resp_hdr.dst_chip_id = req_chip_q;
    resp_hdr.dst_x_coord = req_x_q;
    resp_hdr.dst_y_coord = req_y_q;
    resp_hdr.src_chip_id = `NOC_CHIP_ID_WIDTH'(SRC_CHIP_ID);
    resp_hdr.src_x_coord = `NOC_X_WIDTH'(SRC_X);
    resp_hdr.src_y_coord = `NOC_Y_WIDTH'(SRC_Y);
    resp_hdr.msg_type    = is_load_q ? `MSG_TYPE_LOAD_MEM_ACK : `MSG_TYPE_STORE_MEM_ACK;
    resp_hdr.msg_len     = is_load_q ? resp_len : '0;
    resp_hdr.addr        = addr_q;
    resp_hdr.data_size   = data_size_q;
  end

  always_comb begin
    state_d           = state_q;
    idx_d             = idx_q;
    cnt_d             = cnt_q;
    msg_type_d        = msg_type_q;
    addr_d            = addr_q;
    data_size_d       = data_size_q;
    msg_len_d         = msg_len_q;
    req_chip_d        = req_chip_q;
    req_x_d           = req_x_q;
    req_y_d           = req_y_q;
    mem_we            = 1'b0;
    err_bad_msg       = 1'b0;
    noc.mem_noc0_rdy  = 1'b0;
    noc.mem_noc0_val  = 1'b0;
    noc.mem_noc0_data = resp_hdr;

    unique case (state_q)
      S_IDLE: begin
        noc.mem_noc0_rdy = 1'b1;
        if (noc.noc0_mem_val) begin
          msg_type_d  = req_type;
          addr_d      = req_addr;
          data_size_d = req_size;
          msg_len_d   = req_len;
          req_chip_d  = req_chip;
          req_x_d     = req_x;
          req_y_d     = req_y;
          idx_d       = req_addr[BW +: IDX_W];
          cnt_d       = '0;
          if (req_type == `MSG_TYPE_STORE_MEM) begin
            state_d = (req_len == '0) ? S_STORE_ACK : S_STORE_PAYLOAD;
          end else if (req_type == `MSG_TYPE_LOAD_MEM) begin
            state_d = S_LOAD_HDR;
          end else begin
            err_bad_msg = 1'b1;
          end
        end
      end
      S_STORE_PAYLOAD: begin
        noc.mem_noc0_rdy = 1'b1;
        if (noc.noc0_mem_val) begin
          mem_we = 1'b1;
          idx_d  = idx_inc;
          cnt_d  = cnt_inc;
          if (cnt_inc == msg_len_q) state_d = S_STORE_ACK;
        end
      end
      S_STORE_ACK: begin
        noc.mem_noc0_val = 1'b1;
        if (noc.noc0_mem_rdy) state_d = S_IDLE;
      end
      S_LOAD_HDR: begin
        noc.mem_noc0_val = 1'b1;
        if (noc.noc0_mem_rdy) begin
          cnt_d   = '0;
          state_d = (resp_len == '0) ? S_IDLE : S_LOAD_PAYLOAD;
        end
      end
      S_LOAD_PAYLOAD: begin
        noc.mem_noc0_val  = 1'b1;
        noc.mem_noc0_data = mem_q[idx_q];
        if (noc.noc0_mem_rdy) begin
          idx_d = idx_inc;
          cnt_d = cnt_inc;
          if (cnt_inc == resp_len) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Nothing may be accepted or presented while reset is held.
    if (rst) begin
      noc.mem_noc0_rdy = 1'b0;
      noc.mem_noc0_val = 1'b0;
      err_bad_msg      = 1'b0;
      mem_we           = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      msg_type_q  <= '0;
      addr_q      <= '0;
      data_size_q <= '0;
      msg_len_q   <= '0;
      req_chip_q  <= '0;
      req_x_q     <= '0;
      req_y_q     <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      msg_type_q  <= msg_type_d;
      addr_q      <= addr_d;
      data_size_q <= data_size_d;
      msg_len_q   <= msg_len_d;
      req_chip_q  <= req_chip_d;
      req_x_q     <= req_x_d;
      req_y_q     <= req_y_d;
    end
  end

  // Memory contents survive reset so a requester can read back data written
  // before an aborted transaction.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx_q] <= noc.noc0_mem_data;
  end

endmodule

`default_nettype wire

// File: tb/tb_noc_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_noc_mem_responder
// Description : Scoreboard bench for noc_mem_responder. Requests are driven
//               from tasks; expected response flits are queued at issue time
//               from a word-addressed memory model and popped by a monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_noc_mem_responder;

  localparam int W     = `NOC_DATA_WIDTH;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err_bad_msg;
  always #5 clk = ~clk;

  noc_mem_responder_if bus ();

  noc_mem_responder #(
    .MEM_DEPTH  (DEPTH),
    .SRC_CHIP_ID(0),
    .SRC_X      (1),
    .SRC_Y      (0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .noc        (bus.slave),
    .err_bad_msg(err_bad_msg)
  );

  typedef struct {
    logic [W-1:0] data;
    bit           care;
  } exp_t;

  exp_t         expq[$];
  logic [W-1:0] mm[int];
  int           stored_idx[$];
  int           checks   = 0;
  int           failures = 0;
  int           sink_mode = 0;   // 0: always ready, 1: random, 2: stalled
  bit           drv_bad  = 1'b0;
  logic [13:0]  req_chip = '0;
  logic [7:0]   req_x    = '0;
  logic [7:0]   req_y    = '0;

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [W-1:0] mk_req(input logic [7:0] t, input logic [47:0] a,
                                          input int ds, input int len);
    noc_hdr_flit h;
    h             = '0;
    h.msg_type    = t;
    h.addr        = a;
    h.data_size   = 16'(ds);
    h.msg_len     = 8'(len);
    h.src_chip_id = req_chip;
    h.src_x_coord = req_x;
    h.src_y_coord = req_y;
    h.dst_x_coord = 8'd1;
    return h;
  endfunction

  function automatic logic [W-1:0] ack_hdr(input logic [7:0] t, input logic [47:0] a,
                                           input int ds, input int len);
    noc_hdr_flit h;
    h             = '0;
    h.dst_chip_id = req_chip;
    h.dst_x_coord = req_x;
    h.dst_y_coord = req_y;
    h.src_chip_id = 14'd0;
    h.src_x_coord = 8'd1;
    h.src_y_coord = 8'd0;
    h.msg_type    = t;
    h.msg_len     = 8'(len);
    h.addr        = a;
    h.data_size   = 16'(ds);
    return h;
  endfunction

  function automatic int word_of(input logic [47:0] a);
    return int'((a / 48'd32) % 48'(DEPTH));
  endfunction

  function automatic logic [47:0] addr_at(input int idx);
    logic [47:0] a;
    a = {16'($urandom()), 32'($urandom())};
    a[5 +: 8] = 8'(idx);
    return a;
  endfunction

  // Present one request flit (called at a negedge); returns at the negedge
  // following the edge that transferred it.
  task automatic send(input logic [W-1:0] d, output int waits);
    bus.noc0_mem_val  = 1'b1;
    bus.noc0_mem_data = d;
    waits = 0;
    while (!bus.mem_noc0_rdy && waits < 300) begin
      @(negedge clk);
      waits++;
    end
    if (!bus.mem_noc0_rdy) begin
      checks++;
      failures++;
      $display("FAIL send_timeout waited=%0d cycles", waits);
    end
    @(negedge clk);
  endtask

  task automatic do_store(input logic [47:0] a, input int ds, input int len);
    logic [W-1:0] w[$];
    int           wt;
    int           base;
    base = word_of(a);
    for (int k = 0; k < len; k++) begin
      w.push_back(rand_word());
      mm[(base + k) % DEPTH] = w[k];
      stored_idx.push_back((base + k) % DEPTH);
    end
    expq.push_back('{data: ack_hdr(`MSG_TYPE_STORE_MEM_ACK, a, ds, 0), care: 1'b1});
    send(mk_req(`MSG_TYPE_STORE_MEM, a, ds, len), wt);
    for (int k = 0; k < len; k++) begin
      send(w[k], wt);
      if (k == 0) chk("store_payload_rdy", W'(wt), W'(0));
    end
    bus.noc0_mem_val = 1'b0;
    chk("store_ack_latency", W'(bus.mem_noc0_val), W'(1));
  endtask

  task automatic do_load(input logic [47:0] a, input int ds);
    int wt;
    int base;
    int rl;
    base = word_of(a);
    rl   = ((ds + 31) / 32) % 256;
    expq.push_back('{data: ack_hdr(`MSG_TYPE_LOAD_MEM_ACK, a, ds, rl), care: 1'b1});
    for (int k = 0; k < rl; k++) begin
      if (mm.exists((base + k) % DEPTH))
        expq.push_back('{data: mm[(base + k) % DEPTH], care: 1'b1});
      else
        expq.push_back('{data: '0, care: 1'b0});
    end
    send(mk_req(`MSG_TYPE_LOAD_MEM, a, ds, 0), wt);
    bus.noc0_mem_val = 1'b0;
    chk("load_hdr_latency", W'(bus.mem_noc0_val), W'(1));
  endtask

  task automatic do_bad(input logic [7:0] t);
    int wt;
    drv_bad = 1'b1;
    send(mk_req(t, addr_at(3), 32, 1), wt);
    drv_bad = 1'b0;
    bus.noc0_mem_val = 1'b0;
    chk("bad_no_resp", W'(bus.mem_noc0_val), W'(0));
    chk("bad_stay_idle", W'(bus.mem_noc0_rdy), W'(1));
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((expq.size() != 0 || bus.mem_noc0_val) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue_empty", W'(expq.size()), W'(0));
  endtask

  // Response sink: ready is changed mid-cycle, away from both edges.
  initial begin
    bus.noc0_mem_rdy = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (sink_mode)
        0:       bus.noc0_mem_rdy = 1'b1;
        1:       bus.noc0_mem_rdy = 1'($urandom_range(0, 1));
        default: bus.noc0_mem_rdy = 1'b0;
      endcase
    end
  end

  // Monitor: values seen here are the ones the next rising edge acts on.
  initial begin
    logic         prev_stall;
    logic [W-1:0] prev_data;
    exp_t         e;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        prev_stall = 1'b0;
        continue;
      end
      chk("err_bad_msg", W'(err_bad_msg),
          W'(bus.noc0_mem_val && bus.mem_noc0_rdy && drv_bad));
      if (prev_stall) begin
        chk("hold_val", W'(bus.mem_noc0_val), W'(1));
        chk("hold_data", bus.mem_noc0_data, prev_data);
      end
      if (bus.mem_noc0_val && bus.noc0_mem_rdy) begin
        if (expq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_resp got=%0h exp=none", bus.mem_noc0_data);
        end else begin
          e = expq.pop_front();
          if (e.care) chk("resp_flit", bus.mem_noc0_data, e.data);
        end
      end
      prev_stall = bus.mem_noc0_val && !bus.noc0_mem_rdy;
      prev_data  = bus.mem_noc0_data;
    end
  end

  initial begin
    logic [47:0] a;
    int          r;
    int          t;
    bus.noc0_mem_val  = 1'b0;
    bus.noc0_mem_data = '0;

    // Reset
    repeat (3) @(negedge clk);
    chk("rst_rdy", W'(bus.mem_noc0_rdy), W'(0));
    chk("rst_val", W'(bus.mem_noc0_val), W'(0));
    rst = 1'b0;
    #1;
    chk("reset_rdy", W'(bus.mem_noc0_rdy), W'(1));
    chk("reset_val", W'(bus.mem_noc0_val), W'(0));
    chk("reset_err", W'(err_bad_msg), W'(0));
    @(negedge clk);

    // Store two flits at 0x40, read them back, zero-length load
    do_store(48'h40, 64, 2);
    do_load(48'h40, 40);
    do_load(48'h40, 0);
    wait_drain();

    // Backpressure on the load header, then random stalls on the payload
    sink_mode = 2;
    do_load(48'h40, 64);
    repeat (3) @(negedge clk);
    sink_mode = 1;
    wait_drain();
    sink_mode = 0;

    // Wrap-around from the last word
    do_store(48'((DEPTH - 1) * 32), 96, 3);
    do_load(48'((DEPTH - 1) * 32), 96);

    // Unsupported header dropped, then a normal store completes
    do_bad(`MSG_TYPE_STORE_MEM_ACK);
    do_store(48'h200, 128, 4);
    wait_drain();

    // Reset while streaming load payload
    do_load(48'h200, 128);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    expq.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_val", W'(bus.mem_noc0_val), W'(0));
    chk("abort_rdy", W'(bus.mem_noc0_rdy), W'(1));
    @(negedge clk);
    do_load(48'h200, 128);
    wait_drain();

    // Randomized traffic
    sink_mode = 1;
    for (int n = 0; n < 80; n++) begin
      req_chip = 14'($urandom());
      req_x    = 8'($urandom());
      req_y    = 8'($urandom());
      r = int'($urandom_range(0, 9));
      if (r < 6) begin
        do_store(addr_at(int'($urandom_range(0, DEPTH - 1))),
                 int'($urandom_range(0, 255)), int'($urandom_range(0, 4)));
      end else if (r < 9) begin
        if (stored_idx.size() > 0 && $urandom_range(0, 3) != 0)
          a = addr_at(stored_idx[$urandom_range(0, stored_idx.size() - 1)]);
        else
          a = addr_at(int'($urandom_range(0, DEPTH - 1)));
        do_load(a, int'($urandom_range(0, 160)));
      end else begin
        do
          t = int'($urandom_range(0, 255));
        while (t == 19 || t == 20);
        do_bad(8'(t));
      end
    end
    sink_mode = 0;
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
